// File: rtl/lnvd_feedback_delay_scheduler_if.sv
// Single-port synchronous delay RAM bus between the scheduler (master) and the RAM (slave).
// The RAM returns ram_rdata one clock after ram_addr is presented.
interface lnvd_feedback_delay_scheduler_if #(
    parameter int DW = 12,
    parameter int AW = 10
);
    logic [AW+1:0] ram_addr;
    logic [DW-1:0] ram_wdata;
    logic          ram_we;
    logic [DW-1:0] ram_rdata;

    modport master (
        output ram_addr,
        output ram_wdata,
        output ram_we,
        input  ram_rdata
    );

    modport slave (
        input  ram_addr,
        input  ram_wdata,
        input  ram_we,
        output ram_rdata
    );
endinterface

// File: rtl/lnvd_feedback_delay_scheduler.sv
// Per-strobe read-then-write sequencing of a shared delay RAM for the four LNVD adder inputs.
// Strobe/valid: sample_strobe_i is accepted only in IDLE; buf_valid_o pulses once, 9 cycles later.
module lnvd_feedback_delay_scheduler #(
    parameter int DW            = 12,
    parameter int AW            = 10,
    parameter int DEFAULT_DELAY = 4
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 sample_strobe_i,
    input  logic [4*DW-1:0]                      data_in_i,
    input  logic                                 cfg_load_i,
    input  logic [AW-1:0]                        delay_cfg_i,
    input  logic                                 overrun_clr_i,
    lnvd_feedback_delay_scheduler_if.master      ram,
    output logic [4*DW-1:0]                      buf_out_o,
    output logic                                 buf_valid_o,
    output logic                                 busy_o,
    output logic                                 overrun_o,
    output logic [1:0]                           state_o
);
    typedef enum logic [1:0] {S_IDLE, S_RD, S_WR, S_DONE} state_t;

    localparam logic [AW:0] FILL_MAX = {1'b1, {AW{1'b0}}};

    state_t          state_q, state_d;
    logic [1:0]      ch_q, ch_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW:0]     fill_q, fill_d;
    logic [AW-1:0]   delay_q, delay_d;
    logic            vld_q, vld_d;
    logic [DW-1:0]   s_q [4];
    logic [DW-1:0]   s_d [4];
    logic [DW-1:0]   sh_q [4];
    logic [DW-1:0]   sh_d [4];
    logic [4*DW-1:0] buf_out_q, buf_out_d;
    logic            buf_valid_q, buf_valid_d;
    logic            overrun_q, overrun_d;
    logic [AW+1:0]   addr_q, addr_d;
    logic [DW-1:0]   wdata_q, wdata_d;
    logic            we_q, we_d;

    always_comb begin
        state_d     = state_q;
        ch_d        = ch_q;
        wr_ptr_d    = wr_ptr_q;
        fill_d      = fill_q;
        delay_d     = delay_q;
        vld_d       = vld_q;
        s_d         = s_q;
        sh_d        = sh_q;
        buf_out_d   = buf_out_q;
        buf_valid_d = 1'b0;
        addr_d      = '0;
        wdata_d     = '0;
        we_d        = 1'b0;
        // A strobe that lands outside IDLE is dropped; a simultaneous clear loses.
        if (sample_strobe_i && (state_q != S_IDLE)) begin
            overrun_d = 1'b1;
        end else if (overrun_clr_i) begin
            overrun_d = 1'b0;
        end else begin
            overrun_d = overrun_q;
        end

        case (state_q)
            S_IDLE: begin
                if (cfg_load_i) begin
                    delay_d = (delay_cfg_i == '0) ? AW'(1) : delay_cfg_i;
                    fill_d  = '0;
                end
                if (sample_strobe_i) begin
                    for (int i = 0; i < 4; i++) begin
                        s_d[i] = data_in_i[i*DW +: DW];
                    end
                    vld_d   = (fill_d >= {1'b0, delay_d});
                    ch_d    = 2'd0;
                    addr_d  = {2'd0, wr_ptr_q - delay_d};
                    state_d = S_RD;
                end
            end
            S_RD: begin
                addr_d  = {ch_q, wr_ptr_q};
                wdata_d = s_q[ch_q];
                we_d    = 1'b1;
                state_d = S_WR;
            end
            S_WR: begin
                sh_d[ch_q] = vld_q ? ram.ram_rdata : '0;
                if (ch_q == 2'd3) begin
                    // Outputs are registered, so the last capture is folded in here to land in DONE.
                    buf_out_d   = {sh_d[3], sh_d[2], sh_d[1], sh_d[0]};
                    buf_valid_d = 1'b1;
                    state_d     = S_DONE;
                end else begin
                    ch_d    = ch_q + 2'd1;
                    addr_d  = {ch_d, wr_ptr_q - delay_q};
                    state_d = S_RD;
                end
            end
            S_DONE: begin
                wr_ptr_d = wr_ptr_q + AW'(1);
                if (fill_q != FILL_MAX) begin
                    fill_d = fill_q + (AW+1)'(1);
                end
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            ch_q        <= 2'd0;
            wr_ptr_q    <= '0;
            fill_q      <= '0;
            delay_q     <= AW'(DEFAULT_DELAY);
            vld_q       <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                s_q[i]  <= '0;
                sh_q[i] <= '0;
            end
            buf_out_q   <= '0;
            buf_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            we_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            ch_q        <= ch_d;
            wr_ptr_q    <= wr_ptr_d;
            fill_q      <= fill_d;
            delay_q     <= delay_d;
            vld_q       <= vld_d;
            s_q         <= s_d;
            sh_q        <= sh_d;
            buf_out_q   <= buf_out_d;
            buf_valid_q <= buf_valid_d;
            overrun_q   <= overrun_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            we_q        <= we_d;
        end
    end

    assign ram.ram_addr  = addr_q;
    assign ram.ram_wdata = wdata_q;
    assign ram.ram_we    = we_q;
    assign buf_out_o     = buf_out_q;
    assign buf_valid_o   = buf_valid_q;
    assign busy_o        = (state_q != S_IDLE);
    assign overrun_o     = overrun_q;
    assign state_o       = state_q;
endmodule

// File: tb/tb_lnvd_feedback_delay_scheduler.sv
// Bench for the LNVD delay scheduler: behavioural delay-line model, per-cycle compare, directed pins.
module tb_lnvd_feedback_delay_scheduler;
  localparam int DW = 12;
  localparam int AW = 10;
  localparam int W  = 4*DW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          sample_strobe = 1'b0;
  logic [W-1:0]  data_in = '0;
  logic          cfg_load = 1'b0;
  logic [AW-1:0] delay_cfg = '0;
  logic          overrun_clr = 1'b0;
  logic [W-1:0]  buf_out;
  logic          buf_valid, busy, overrun;
  logic [1:0]    state_dbg;

  lnvd_feedback_delay_scheduler_if #(.DW(DW), .AW(AW)) ram_if ();

  lnvd_feedback_delay_scheduler #(.DW(DW), .AW(AW), .DEFAULT_DELAY(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .sample_strobe_i(sample_strobe), .data_in_i(data_in),
    .cfg_load_i(cfg_load), .delay_cfg_i(delay_cfg), .overrun_clr_i(overrun_clr),
    .ram(ram_if),
    .buf_out_o(buf_out), .buf_valid_o(buf_valid), .busy_o(busy),
    .overrun_o(overrun), .state_o(state_dbg)
  );

  // ---------------- clock / RAM ----------------
  always #5 clk = ~clk;

  logic [DW-1:0] mem [4*(2**AW)];
  always @(posedge clk) begin
    if (ram_if.ram_we) mem[ram_if.ram_addr] <= ram_if.ram_wdata;
    ram_if.ram_rdata <= mem[ram_if.ram_addr];
  end

  // ---------------- scoreboard bookkeeping ----------------
  int n_vec = 0;
  int n_err = 0;

  function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endfunction

  // ---------------- behavioural model ----------------
  // Delay line in strobe units: output at an accepted strobe is the sample accepted
  // 'dly' strobes earlier since the last reset/config, or 0 if there is none yet.
  int            edge_n   = 0;
  int            last_acc = -100;
  int            dly_m    = 4;
  logic [AW-1:0] wr_m     = '0;
  logic          ov_m     = 1'b0;
  logic [W-1:0]  hist[$];
  logic [W-1:0]  exp_q[$];
  logic [W-1:0]  exp_buf  = '0;
  logic [AW-1:0] seq_ptr  = '0;
  int            seq_dly  = 0;
  logic [W-1:0]  seq_s    = '0;

  initial begin
    forever begin
      @(posedge clk);
      edge_n++;
      if (!rst_n) begin
        last_acc = -100; dly_m = 4; wr_m = '0; ov_m = 1'b0;
        hist.delete(); exp_q.delete(); exp_buf = '0;
      end else begin
        automatic bit bsy = (edge_n - last_acc >= 1) && (edge_n - last_acc <= 9);
        if (sample_strobe && bsy) ov_m = 1'b1;
        else if (overrun_clr) ov_m = 1'b0;
        if (cfg_load && !bsy) begin
          dly_m = (delay_cfg == 0) ? 1 : int'(delay_cfg);
          hist.delete();
        end
        if (sample_strobe && !bsy) begin
          if (hist.size() >= dly_m) exp_q.push_back(hist[hist.size() - dly_m]);
          else exp_q.push_back('0);
          hist.push_back(data_in);
          if (hist.size() > 1100) void'(hist.pop_front());
          seq_ptr = wr_m; seq_dly = dly_m; seq_s = data_in;
          wr_m = wr_m + AW'(1);
          last_acc = edge_n;
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        chk("rst_buf_out", 64'(buf_out), 64'd0);
        chk("rst_valid", 64'(buf_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_overrun", 64'(overrun), 64'd0);
        chk("rst_we", 64'(ram_if.ram_we), 64'd0);
        chk("rst_addr", 64'(ram_if.ram_addr), 64'd0);
        chk("rst_wdata", 64'(ram_if.ram_wdata), 64'd0);
      end else begin
        automatic int d = edge_n - last_acc;
        automatic logic [1:0] ch = 2'(d / 2);
        automatic logic [AW-1:0] rp = seq_ptr - AW'(seq_dly);
        chk("busy", 64'(busy), 64'(d >= 0 && d <= 8));
        chk("overrun", 64'(overrun), 64'(ov_m));
        chk("ram_we", 64'(ram_if.ram_we), 64'(d >= 1 && d <= 7 && (d % 2) == 1));
        if (d >= 0 && d <= 7) begin
          if ((d % 2) == 0) begin
            chk("rd_addr", 64'(ram_if.ram_addr), 64'({ch, rp}));
          end else begin
            chk("wr_addr", 64'(ram_if.ram_addr), 64'({ch, seq_ptr}));
            chk("wr_data", 64'(ram_if.ram_wdata), 64'(seq_s[ch*DW +: DW]));
          end
        end
        if (d == 8) begin
          if (exp_q.size() == 0) chk("exp_q_underflow", 64'd1, 64'd0);
          else exp_buf = exp_q.pop_front();
        end
        chk("buf_valid", 64'(buf_valid), 64'(d == 8));
        chk("buf_out", 64'(buf_out), 64'(exp_buf));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle(2);
    rst_n = 1'b1;
    idle(1);
  endtask

  task automatic strobe(input logic [W-1:0] d);
    sample_strobe = 1'b1;
    data_in = d;
    idle(1);
    sample_strobe = 1'b0;
  endtask

  task automatic cfg(input logic [AW-1:0] v);
    cfg_load = 1'b1;
    delay_cfg = v;
    idle(1);
    cfg_load = 1'b0;
  endtask

  // Returns the negedge index (from now) at which buf_valid was seen; 0 on timeout.
  task automatic wait_valid(output int n);
    n = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (buf_valid) begin
        n = i;
        break;
      end
    end
    if (n == 0) chk("valid_timeout", 64'd1, 64'd0);
    @(posedge clk);
    #1;
  endtask

  function automatic logic [W-1:0] pat(input int n);
    return {12'(16*n+3), 12'(16*n+2), 12'(16*n+1), 12'(16*n)};
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    int lat;
    logic [W-1:0] a, b, c, e;
    do_reset();

    // Delay 2, five strobes 20 cycles apart.
    cfg(10'd2);
    for (int n = 0; n < 5; n++) begin
      strobe(pat(n));
      wait_valid(lat);
      chk("t1_latency", 64'(lat), 64'd9);
      if (n == 2) chk("t1_n2", 64'(buf_out), 64'h003002001000);
      else if (n == 4) chk("t1_n4", 64'(buf_out), 64'h023022021020);
      else if (n < 2) chk("t1_zero", 64'(buf_out), 64'd0);
      idle(10);
    end

    // RAM trace with wr_ptr=5, delay=2.
    strobe(pat(9));
    @(negedge clk);
    chk("t2_c1_addr", 64'(ram_if.ram_addr), 64'h003);
    chk("t2_c1_we", 64'(ram_if.ram_we), 64'd0);
    @(negedge clk);
    chk("t2_c2_addr", 64'(ram_if.ram_addr), 64'h005);
    chk("t2_c2_we", 64'(ram_if.ram_we), 64'd1);
    repeat (6) @(negedge clk);
    chk("t2_c8_addr", 64'(ram_if.ram_addr), 64'hC05);
    chk("t2_c8_we", 64'(ram_if.ram_we), 64'd1);
    @(negedge clk);
    chk("t2_c9_we", 64'(ram_if.ram_we), 64'd0);
    @(posedge clk); #1;
    strobe(pat(10));
    @(negedge clk); @(negedge clk);
    chk("t2_next_ptr", 64'(ram_if.ram_addr), 64'h006);
    wait_valid(lat);

    // Pointer wrap with delay 3.
    do_reset();
    cfg(10'd3);
    for (int i = 0; i < 1030; i++) begin
      strobe({$urandom, $urandom} & {W{1'b1}});
      if (i == 1025) begin
        @(negedge clk);
        chk("t3_wrap_rd", 64'(ram_if.ram_addr), 64'h3FE);
      end
      idle(9);
    end

    // Overrun.
    do_reset();
    a = pat(20);
    strobe(a);
    idle(3);
    strobe(pat(21));
    @(negedge clk);
    chk("t4_ovr_set", 64'(overrun), 64'd1);
    wait_valid(lat);
    overrun_clr = 1'b1;
    idle(1);
    overrun_clr = 1'b0;
    @(negedge clk);
    chk("t4_ovr_clr", 64'(overrun), 64'd0);
    idle(1);
    strobe(pat(22));
    idle(2);
    strobe(pat(23));
    sample_strobe = 1'b1; overrun_clr = 1'b1;
    idle(1);
    sample_strobe = 1'b0; overrun_clr = 1'b0;
    @(negedge clk);
    chk("t4_set_wins", 64'(overrun), 64'd1);
    wait_valid(lat);

    // Config.
    do_reset();
    cfg(10'd0);
    a = pat(30); b = pat(31); c = pat(32); e = pat(34);
    strobe(a); wait_valid(lat);
    chk("t5_d1_first", 64'(buf_out), 64'd0);
    strobe(b); wait_valid(lat);
    chk("t5_d1_second", 64'(buf_out), 64'(a));
    strobe(c); idle(2); cfg(10'd7); wait_valid(lat);
    chk("t5_busy_cfg", 64'(buf_out), 64'(b));
    strobe(pat(33)); wait_valid(lat);
    chk("t5_busy_cfg_ignored", 64'(buf_out), 64'(c));
    cfg_load = 1'b1; delay_cfg = 10'd1;
    strobe(e);
    cfg_load = 1'b0;
    wait_valid(lat);
    chk("t5_cfg_strobe_zero", 64'(buf_out), 64'd0);
    strobe(pat(35)); wait_valid(lat);
    chk("t5_cfg_strobe_next", 64'(buf_out), 64'(e));

    // Reset mid-sequence.
    strobe(pat(40));
    idle(4);
    rst_n = 1'b0;
    @(negedge clk);
    chk("t6_busy", 64'(busy), 64'd0);
    chk("t6_we", 64'(ram_if.ram_we), 64'd0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    idle(1);
    a = pat(41);
    for (int n = 0; n < 5; n++) begin
      strobe(n == 0 ? a : pat(42 + n));
      wait_valid(lat);
      chk("t6_after_reset", 64'(buf_out), (n == 4) ? 64'(a) : 64'd0);
    end

    // Random phase: spacing, configs and clears all randomised.
    for (int i = 0; i < 300; i++) begin
      sample_strobe = ($urandom_range(0, 9) < 8);
      data_in = {$urandom, $urandom} & {W{1'b1}};
      cfg_load = ($urandom_range(0, 9) == 0);
      delay_cfg = AW'($urandom_range(0, 6));
      overrun_clr = ($urandom_range(0, 4) == 0);
      idle(1);
      sample_strobe = 1'b0; cfg_load = 1'b0; overrun_clr = 1'b0;
      idle($urandom_range(3, 14));
    end
    idle(20);
    chk("exp_q_drained", 64'(exp_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    n_err++;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $fatal(1, "watchdog");
  end
endmodule
